// File: rtl/hazard_unit_mc_pkg.sv
// Shared types and constants for the multi-cycle hazard unit.
package hazard_unit_mc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdState_t;

  localparam logic [1:0] FWD_RF     = 2'b00;
  localparam logic [1:0] FWD_WB     = 2'b01;
  localparam logic [1:0] FWD_MEM    = 2'b10;
  localparam logic [1:0] WBSEL_LOAD = 2'b00;

  // Memory-stage producer wins over writeback: it holds the younger value.
  function automatic logic [1:0] fwdPick(input logic hitM, input logic hitW);
    if (hitM)      return FWD_MEM;
    else if (hitW) return FWD_WB;
    else           return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_unit_mc_if.sv
// Pipeline-to-hazard-unit signal bundle.
interface hazard_unit_mc_if #(
  parameter int REG_W = 5
);
  logic [REG_W-1:0] rs1D, rs2D;
  logic [REG_W-1:0] rs1E, rs2E, rdE;
  logic [REG_W-1:0] rdM, rdW;
  logic             regwriteM, regwriteW;
  logic [1:0]       wbselE;
  logic             pcsrcE, mdopE;
  logic             memreqM, memreadyM;
  logic             stallF, stallD, stallE, stallM;
  logic             flushD, flushE, flushM, flushW;
  logic [1:0]       forwardAE, forwardBE;
  logic             mdbusy;

  // Pipeline side: supplies stage information, consumes controls.
  modport master (
    output rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW, regwriteM, regwriteW,
           wbselE, pcsrcE, mdopE, memreqM, memreadyM,
    input  stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW,
           forwardAE, forwardBE, mdbusy
  );

  // Hazard unit side.
  modport slave (
    input  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW, regwriteM, regwriteW,
           wbselE, pcsrcE, mdopE, memreqM, memreadyM,
    output stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW,
           forwardAE, forwardBE, mdbusy
  );
endinterface

// File: rtl/hazard_unit_mc_md_stall_fsm.sv
// Mul/div occupancy tracker: holds Execute for MD_LAT-1 cycles per operation.
module md_stall_fsm
  import hazard_unit_mc_pkg::*;
#(
  parameter int MD_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic mdop,
  input  logic memstall,
  output logic mdstall,
  output logic mdbusy
);

  localparam int CNT_W = $clog2(MD_LAT) + 1;
  localparam bit MULTI = (MD_LAT > 1);
  // First stall cycle happens in IDLE, so BUSY needs MD_LAT-2 more.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULTI ? MD_LAT - 2 : 0);

  mdState_t         stateReg;
  logic [CNT_W-1:0] cntReg;
  logic             mdbusyReg;

  // State, counter and busy flag advance together; a memory stall freezes all of them.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg  <= IDLE;
      cntReg    <= '0;
      mdbusyReg <= 1'b0;
    end else if (!memstall) begin
      case (stateReg)
        IDLE: begin
          if (MULTI && mdop) begin
            stateReg  <= BUSY;
            cntReg    <= CNT_LOAD;
            mdbusyReg <= 1'b1;
          end
        end
        BUSY: begin
          if (cntReg != '0) begin
            cntReg <= cntReg - CNT_W'(1);
          end else begin
            stateReg  <= IDLE;
            mdbusyReg <= 1'b0;
          end
        end
        default: begin
          stateReg  <= IDLE;
          mdbusyReg <= 1'b0;
        end
      endcase
    end
  end

  // Stall starts the same cycle the op appears in Execute; reset masks it.
  always_comb begin
    mdstall = 1'b0;
    if (!rst) begin
      if (stateReg == IDLE) mdstall = MULTI && mdop && !memstall;
      else                  mdstall = (cntReg != '0);
    end
  end

  assign mdbusy = mdbusyReg;

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard unit: operand forwarding plus prioritised stall/flush generation.
module hazard_unit_mc
  import hazard_unit_mc_pkg::*;
#(
  parameter int REG_W  = 5,
  parameter int MD_LAT = 4
) (
  input logic             clk,
  input logic             rst,
  hazard_unit_mc_if.slave hz
);

  logic [1:0] fwdSel [2];
  logic [REG_W-1:0] srcE [2];
  logic memstall, lwstall, mdstall;

  assign srcE[0] = hz.rs1E;
  assign srcE[1] = hz.rs2E;

  // One forwarding mux select per Execute source operand.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : gFwd
      always_comb begin
        fwdSel[gi] = fwdPick(hz.regwriteM && (hz.rdM != '0) && (srcE[gi] == hz.rdM),
                             hz.regwriteW && (hz.rdW != '0) && (srcE[gi] == hz.rdW));
      end
    end
  endgenerate

  assign hz.forwardAE = fwdSel[0];
  assign hz.forwardBE = fwdSel[1];

  assign memstall = hz.memreqM & ~hz.memreadyM;
  assign lwstall  = (hz.wbselE == WBSEL_LOAD) && (hz.rdE != '0) &&
                    ((hz.rs1D == hz.rdE) || (hz.rs2D == hz.rdE));

  md_stall_fsm #(.MD_LAT(MD_LAT)) uMdFsm (
    .clk      (clk),
    .rst      (rst),
    .mdop     (hz.mdopE),
    .memstall (memstall),
    .mdstall  (mdstall),
    .mdbusy   (hz.mdbusy)
  );

  // Highest-priority hazard decides; a pending redirect is held off while anything stalls Execute.
  always_comb begin
    hz.stallF = 1'b0;
    hz.stallD = 1'b0;
    hz.stallE = 1'b0;
    hz.stallM = 1'b0;
    hz.flushD = 1'b0;
    hz.flushE = 1'b0;
    hz.flushM = 1'b0;
    hz.flushW = 1'b0;
    if (memstall) begin
      hz.stallF = 1'b1;
      hz.stallD = 1'b1;
      hz.stallE = 1'b1;
      hz.stallM = 1'b1;
      hz.flushW = 1'b1;
    end else if (mdstall) begin
      hz.stallF = 1'b1;
      hz.stallD = 1'b1;
      hz.stallE = 1'b1;
      hz.flushM = 1'b1;
    end else if (lwstall) begin
      hz.stallF = 1'b1;
      hz.stallD = 1'b1;
      hz.flushE = 1'b1;
      hz.flushD = hz.pcsrcE;
    end else begin
      hz.flushD = hz.pcsrcE;
      hz.flushE = hz.pcsrcE;
    end
  end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed bench for hazard_unit_mc with a cycle-level reference model.
module tb_hazard_unit_mc;

  localparam int MD_LAT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  bit   cmpEn    = 1'b0;

  // Model: an accepted mul/div takes MD_LAT-1 stall cycles, then one advance cycle.
  bit opActive    = 1'b0;
  int stallsTaken = 0;

  hazard_unit_mc_if #(.REG_W(5)) hu ();

  hazard_unit_mc #(.REG_W(5), .MD_LAT(MD_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hu)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] fwdModel(input logic [4:0] rs);
    if (hu.regwriteM && hu.rdM != 0 && rs == hu.rdM) return 2'b10;
    if (hu.regwriteW && hu.rdW != 0 && rs == hu.rdW) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [12:0] expected();
    logic ms, ls, md;
    logic sF, sD, sE, sM, fD, fE, fM, fW;
    ms = hu.memreqM && !hu.memreadyM;
    ls = (hu.wbselE == 2'b00) && (hu.rdE != 0) && (hu.rs1D == hu.rdE || hu.rs2D == hu.rdE);
    if (rst)           md = 1'b0;
    else if (opActive) md = (stallsTaken < MD_LAT - 1);
    else               md = hu.mdopE && (MD_LAT > 1) && !ms;
    {sF, sD, sE, sM, fD, fE, fM, fW} = '0;
    if (ms)      begin sF = 1; sD = 1; sE = 1; sM = 1; fW = 1; end
    else if (md) begin sF = 1; sD = 1; sE = 1; fM = 1; end
    else if (ls) begin sF = 1; sD = 1; fE = 1; fD = hu.pcsrcE; end
    else         begin fD = hu.pcsrcE; fE = hu.pcsrcE; end
    return {sF, sD, sE, sM, fD, fE, fM, fW, fwdModel(hu.rs1E), fwdModel(hu.rs2E), opActive};
  endfunction

  // Advance the model on each active edge from the inputs held during that cycle.
  always @(posedge clk) begin
    if (rst) begin
      opActive    = 1'b0;
      stallsTaken = 0;
    end else if (!(hu.memreqM && !hu.memreadyM)) begin
      if (opActive) begin
        if (stallsTaken < MD_LAT - 1) stallsTaken++;
        else                          opActive = 1'b0;
      end else if (hu.mdopE && MD_LAT > 1) begin
        opActive    = 1'b1;
        stallsTaken = 1;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (cmpEn) begin
      chk("cycle_outputs",
          {19'd0, hu.stallF, hu.stallD, hu.stallE, hu.stallM, hu.flushD, hu.flushE,
           hu.flushM, hu.flushW, hu.forwardAE, hu.forwardBE, hu.mdbusy},
          {19'd0, expected()});
    end
  end

  task automatic clearIn();
    hu.rs1D = 0; hu.rs2D = 0; hu.rs1E = 0; hu.rs2E = 0; hu.rdE = 0;
    hu.rdM = 0; hu.rdW = 0; hu.regwriteM = 0; hu.regwriteW = 0;
    hu.wbselE = 2'b01; hu.pcsrcE = 0; hu.mdopE = 0; hu.memreqM = 0; hu.memreadyM = 1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  int stallCnt;

  initial begin
    clearIn();
    rst = 1'b1;
    nextCycle();
    cmpEn = 1'b1;
    nextCycle();
    settle();
    chk("reset_mdbusy", hu.mdbusy, 0);
    chk("reset_stallE", hu.stallE, 0);
    rst = 1'b0;

    // Forwarding: M beats W, then W when M target is x0
    nextCycle();
    hu.rs1E = 5; hu.rdM = 5; hu.regwriteM = 1; hu.rdW = 5; hu.regwriteW = 1;
    settle();
    chk("fwdA_mem", hu.forwardAE, 2'b10);
    nextCycle();
    hu.rdM = 0;
    settle();
    chk("fwdA_wb", hu.forwardAE, 2'b01);
    nextCycle();
    hu.rs2E = 9; hu.rdW = 9; hu.rdM = 9; hu.regwriteM = 0;
    settle();
    chk("fwdB_wb_mem_disabled", hu.forwardBE, 2'b01);
    chk("fwdA_none", hu.forwardAE, 2'b00);

    // Load-use stall, one cycle, then x0 destination
    nextCycle();
    clearIn();
    hu.wbselE = 2'b00; hu.rdE = 7; hu.rs2D = 7; hu.pcsrcE = 1;
    settle();
    chk("lw_stall", {hu.stallF, hu.stallD, hu.flushE, hu.flushD, hu.stallE}, 5'b11110);
    nextCycle();
    clearIn();
    settle();
    chk("lw_gone", {hu.stallF, hu.stallD, hu.flushE}, 3'b000);
    nextCycle();
    hu.wbselE = 2'b00; hu.rdE = 0; hu.rs1D = 0; hu.rs2D = 0;
    settle();
    chk("lw_rd0", {hu.stallF, hu.stallD, hu.flushE}, 3'b000);

    // Mul/div: 3 stall cycles, busy in cycles 2-4, then a fresh back-to-back op
    nextCycle();
    clearIn();
    hu.mdopE = 1;
    for (int c = 1; c <= 4; c++) begin
      settle();
      chk($sformatf("md_stallE_c%0d", c), hu.stallE, (c <= 3) ? 1 : 0);
      chk($sformatf("md_busy_c%0d", c), hu.mdbusy, (c >= 2) ? 1 : 0);
      nextCycle();
    end
    settle();
    chk("md_fresh_stallE", hu.stallE, 1);
    chk("md_fresh_busy", hu.mdbusy, 0);
    for (int c = 0; c < 3; c++) nextCycle();
    hu.mdopE = 0;
    nextCycle();

    // Memory stall in the middle of BUSY stretches the Execute stall to 5
    stallCnt = 0;
    hu.mdopE = 1;
    for (int c = 1; c <= 7; c++) begin
      hu.memreqM   = (c == 2 || c == 3);
      hu.memreadyM = !(c == 2 || c == 3);
      settle();
      if (c == 2) chk("memstall_stallM_flushW", {hu.stallM, hu.flushW, hu.flushM}, 3'b110);
      if (hu.stallE) stallCnt++;
      if (c == 6) chk("md_mem_advance", hu.stallE, 0);
      nextCycle();
      if (c == 6) hu.mdopE = 0;
    end
    chk("md_mem_total_stall", stallCnt, 5);
    clearIn();

    // Redirect suppressed by memory stall, released when ready rises
    nextCycle();
    hu.pcsrcE = 1; hu.memreqM = 1; hu.memreadyM = 0;
    settle();
    chk("pcsrc_memstall", {hu.flushD, hu.flushE, hu.flushW}, 3'b001);
    nextCycle();
    hu.memreadyM = 1;
    settle();
    chk("pcsrc_release", {hu.flushD, hu.flushE, hu.flushW}, 3'b110);
    nextCycle();
    clearIn();

    // Reset during BUSY with one stall cycle left
    hu.mdopE = 1;
    nextCycle();
    nextCycle();
    rst = 1'b1;
    settle();
    chk("rst_mdstall_masked", hu.stallE, 0);
    nextCycle();
    rst = 1'b0;
    settle();
    chk("rst_idle_busy", hu.mdbusy, 0);
    chk("rst_fresh_stallE", hu.stallE, 1);
    hu.mdopE = 1;
    for (int c = 0; c < 4; c++) nextCycle();
    clearIn();
    nextCycle();
    nextCycle();

    cmpEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
